uart_rx_frame_ctrl: RTL and testbench

Frame-level receive controller that drains the UART receive FIFO, hunts for a sync byte, and assembles length-prefixed, checksummed frames into an internal payload buffer. It sits between the receive path's FIFO read port (`rd_uart` / `rx_empty` / `R_data`) and the command logic. It sequences every FIFO pop, validates each frame, and presents a complete frame to the consumer through a random-access read port until the consumer acknowledges it.

---
 rtl/uart_rx_frame_ctrl.sv | 128 ++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
`timescale 1ns/1ps
// Frame-level UART receive controller: hunts for the sync byte, assembles length-prefixed,
// checksummed frames into a payload buffer and holds each one until the consumer acks it.
module uart_rx_frame_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_LEN = 16,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE = 8'hA5,
  parameter int unsigned TIMEOUT = 1024,
  localparam int unsigned LenW = $clog2(MAX_LEN + 1),
  localparam int unsigned AddrW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1)
) (
  input  logic                  UCLK,
  input  logic                  reset,
  input  logic                  rx_empty,
  input  logic [DATA_WIDTH-1:0] R_data,
  output logic                  rd_uart,
  output logic                  frm_valid,
  output logic [LenW-1:0]       frm_len,
  input  logic [AddrW-1:0]      frm_addr,
  output logic [DATA_WIDTH-1:0] frm_data,
  input  logic                  frm_ack,
  output logic [7:0]            err_cnt,
  output logic [1:0]            err_code
);

  typedef enum logic [2:0] {StHunt, StLen, StPayload, StCsum, StHold} state_e;

  state_e                state_q;
  logic                  pend_q;
  logic [LenW-1:0]       len_q;
  logic [LenW-1:0]       idx_q;
  logic [DATA_WIDTH-1:0] sum_q;
  logic [TmoW-1:0]       tmo_q;
  logic [DATA_WIDTH-1:0] pay_q [MAX_LEN];

  logic            cap;
  logic            in_frame;
  logic            len_bad;
  logic            tmo_hit;
  logic [7:0]      err_cnt_inc;
  logic [LenW-1:0] idx_nxt;

  // The pop is combinational so a byte can be requested the very cycle the FIFO fills.
  assign rd_uart     = !rx_empty && (state_q != StHold) && !pend_q;
  assign cap         = pend_q;
  assign in_frame    = (state_q == StLen) || (state_q == StPayload) || (state_q == StCsum);
  assign len_bad     = (R_data == '0) || (32'(R_data) > MAX_LEN);
  assign tmo_hit     = in_frame && !cap && (tmo_q == TmoW'(TIMEOUT - 1));
  assign err_cnt_inc = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
  assign idx_nxt     = idx_q + LenW'(1);
  assign frm_len     = len_q;
  assign frm_data    = pay_q[frm_addr];

  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) begin
      state_q   <= StHunt;
      pend_q    <= 1'b0;
      frm_valid <= 1'b0;
      len_q     <= '0;
      idx_q     <= '0;
      sum_q     <= '0;
      tmo_q     <= '0;
      err_cnt   <= '0;
      err_code  <= '0;
    end else begin
      pend_q <= rd_uart;
      if (in_frame && !cap && !tmo_hit) tmo_q <= tmo_q + TmoW'(1);
      else                              tmo_q <= '0;

      if (tmo_hit) begin
        state_q  <= StHunt;
        err_cnt  <= err_cnt_inc;
        err_code <= 2'd3;
      end else begin
        case (state_q)
          StHunt: if (cap && (R_data == SYNC_BYTE)) state_q <= StLen;
          StLen: begin
            if (cap) begin
              if (len_bad) begin
                state_q  <= StHunt;
                err_cnt  <= err_cnt_inc;
                err_code <= 2'd1;
              end else begin
                len_q   <= R_data[LenW-1:0];
                sum_q   <= R_data;
                idx_q   <= '0;
                state_q <= StPayload;
              end
            end
          end
          StPayload: begin
            if (cap) begin
              sum_q <= sum_q + R_data;
              idx_q <= idx_nxt;
              if (idx_nxt == len_q) state_q <= StCsum;
            end
          end
          StCsum: begin
            if (cap) begin
              if (R_data == sum_q) begin
                state_q   <= StHold;
                frm_valid <= 1'b1;
              end else begin
                state_q  <= StHunt;
                err_cnt  <= err_cnt_inc;
                err_code <= 2'd2;
              end
            end
          end
          StHold: begin
            if (frm_ack) begin
              state_q   <= StHunt;
              frm_valid <= 1'b0;
            end
          end
          default: state_q <= StHunt;
        endcase
      end
    end
  end

  // Payload storage needs no reset: frm_valid alone qualifies its contents.
  always_ff @(posedge UCLK) begin
    if ((state_q == StPayload) && cap) pay_q[idx_q[AddrW-1:0]] <= R_data;
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
`timescale 1ns/1ps
// Directed and randomized bench for uart_rx_frame_ctrl with a queue-based FIFO and a
// frame-level reference model.
module tb_uart_rx_frame_ctrl;
  localparam int unsigned MaxLen  = 16;
  localparam int unsigned Timeout = 20;

  logic       UCLK = 1'b0;
  logic       reset = 1'b0;
  logic       rx_empty = 1'b1;
  logic [7:0] R_data = '0;
  logic       rd_uart;
  logic       frm_valid;
  logic [4:0] frm_len;
  logic [3:0] frm_addr = '0;
  logic [7:0] frm_data;
  logic       frm_ack = 1'b0;
  logic [7:0] err_cnt;
  logic [1:0] err_code;

  uart_rx_frame_ctrl #(.DATA_WIDTH(8), .MAX_LEN(MaxLen), .SYNC_BYTE(8'hA5),
                       .TIMEOUT(Timeout)) dut (
    .UCLK(UCLK), .reset(reset), .rx_empty(rx_empty), .R_data(R_data), .rd_uart(rd_uart),
    .frm_valid(frm_valid), .frm_len(frm_len), .frm_addr(frm_addr), .frm_data(frm_data),
    .frm_ack(frm_ack), .err_cnt(err_cnt), .err_code(err_code)
  );

  always #5 UCLK = ~UCLK;

  int nchecks = 0;
  int nerrors = 0;
  int cyc = 0;
  int last_pop_cyc = -10;
  int first_pop_cyc = -1;
  logic [7:0] fifo [$];
  int exp_err = 0;
  logic [1:0] exp_code = 2'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural FIFO: data appears on R_data the cycle after a pop.
  always @(posedge UCLK) begin
    cyc <= cyc + 1;
    if (rd_uart && fifo.size() > 0) begin
      R_data   <= fifo.pop_front();
      rx_empty <= (fifo.size() == 0);
    end
  end

  // Pop protocol monitor.
  always @(negedge UCLK) begin
    if (rd_uart && reset) begin
      check("pop_nonempty", {31'd0, rx_empty}, 32'd0);
      check("pop_spacing", (cyc - last_pop_cyc >= 2) ? 32'd1 : 32'd0, 32'd1);
      check("pop_not_hold", {31'd0, frm_valid}, 32'd0);
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
    end
  end

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    rx_empty = 1'b0;
  endtask

  function automatic logic [7:0] csum_of(input logic [7:0] len, input logic [7:0] pl [$]);
    int s = len;
    foreach (pl[i]) s += pl[i];
    return 8'(s % 256);
  endfunction

  task automatic push_frame(input logic [7:0] len, input logic [7:0] pl [$],
                            input logic [7:0] cs);
    push(8'hA5);
    push(len);
    foreach (pl[i]) push(pl[i]);
    push(cs);
  endtask

  task automatic note_abort(input logic [1:0] code);
    if (exp_err < 255) exp_err++;
    exp_code = code;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!frm_valid && n < 400) begin
      @(negedge UCLK);
      n++;
    end
    check({tag, "_valid"}, {31'd0, frm_valid}, 32'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (fifo.size() > 0 && n < 400) begin
      @(negedge UCLK);
      n++;
    end
    repeat (4) @(negedge UCLK);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] pl [$]);
    check({tag, "_len"}, {27'd0, frm_len}, pl.size());
    foreach (pl[i]) begin
      frm_addr = 4'(i);
      #1;
      check({tag, "_data"}, {24'd0, frm_data}, {24'd0, pl[i]});
    end
    check({tag, "_errcnt"}, {24'd0, err_cnt}, exp_err);
  endtask

  task automatic ack();
    frm_ack = 1'b1;
    @(negedge UCLK);
    frm_ack = 1'b0;
    check("ack_release", {31'd0, frm_valid}, 32'd0);
  endtask

  task automatic check_err(input string tag);
    check({tag, "_nvalid"}, {31'd0, frm_valid}, 32'd0);
    check({tag, "_errcnt"}, {24'd0, err_cnt}, exp_err);
    check({tag, "_errcode"}, {30'd0, err_code}, {30'd0, exp_code});
  endtask

  initial begin
    logic [7:0] pl [$];
    logic [7:0] pl2 [$];
    int t_err;
    int n;

    // Reset values
    repeat (2) @(negedge UCLK);
    check("rst_rd", {31'd0, rd_uart}, 32'd0);
    check("rst_valid", {31'd0, frm_valid}, 32'd0);
    check("rst_len", {27'd0, frm_len}, 32'd0);
    check("rst_errcnt", {24'd0, err_cnt}, 32'd0);
    check("rst_errcode", {30'd0, err_code}, 32'd0);
    reset = 1'b1;
    @(negedge UCLK);

    // Basic 3-byte frame and best-case latency
    pl = '{8'h11, 8'h22, 8'h33};
    first_pop_cyc = -1;
    push_frame(8'd3, pl, csum_of(8'd3, pl));
    wait_valid("basic");
    check("basic_latency", cyc - first_pop_cyc, 2 * (3 + 3));
    check_frame("basic", pl);

    // A queued frame must not be popped while holding
    pl2 = '{8'h5A};
    push_frame(8'd1, pl2, csum_of(8'd1, pl2));
    repeat (10) @(negedge UCLK);
    check("hold_nopop", fifo.size(), 4);
    check("hold_valid", {31'd0, frm_valid}, 32'd1);
    check_frame("hold_stable", pl);
    ack();
    wait_valid("queued");
    check_frame("queued", pl2);
    ack();

    // Leading garbage is discarded
    push(8'h00);
    push(8'hFF);
    pl = '{8'h01, 8'h02};
    push_frame(8'd2, pl, 8'h05);
    wait_valid("garbage");
    check_frame("garbage", pl);
    ack();

    // Bad checksum, then a good frame
    push_frame(8'd2, pl, 8'h06);
    note_abort(2'd2);
    wait_drain();
    check_err("badcsum");
    push_frame(8'd2, pl, 8'h05);
    wait_valid("after_csum");
    check_frame("after_csum", pl);
    ack();

    // Zero and oversize lengths
    push(8'hA5);
    push(8'h00);
    push(8'hA5);
    push(8'(MaxLen + 1));
    note_abort(2'd1);
    note_abort(2'd1);
    wait_drain();
    check_err("badlen");

    // Inter-byte timeout: abort exactly Timeout cycles after the last capture
    push(8'hA5);
    push(8'h03);
    push(8'h11);
    note_abort(2'd3);
    n = 0;
    while (err_cnt == 8'(exp_err - 1) && n < 200) begin
      @(negedge UCLK);
      n++;
    end
    t_err = cyc;
    check("tmo_delay", t_err - last_pop_cyc, Timeout + 2);
    check_err("tmo");

    // Randomized frames against the frame-level model
    for (int it = 0; it < 40; it++) begin
      int kind = $urandom_range(0, 3);
      int g = $urandom_range(0, 3);
      int len = $urandom_range(1, MaxLen);
      logic [7:0] lb;
      for (int k = 0; k < g; k++) begin
        logic [7:0] b = 8'($urandom_range(0, 255));
        push((b == 8'hA5) ? 8'h3C : b);
      end
      pl.delete();
      for (int k = 0; k < len; k++) pl.push_back(8'($urandom_range(0, 255)));
      if (kind == 0) begin
        lb = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MaxLen + 1, 255));
        push(8'hA5);
        push(lb);
        note_abort(2'd1);
        wait_drain();
        check_err("rnd_len");
      end else if (kind == 1) begin
        push_frame(8'(len), pl, csum_of(8'(len), pl) ^ 8'($urandom_range(1, 255)));
        note_abort(2'd2);
        wait_drain();
        check_err("rnd_csum");
      end else begin
        push_frame(8'(len), pl, csum_of(8'(len), pl));
        wait_valid("rnd");
        check_frame("rnd", pl);
        ack();
      end
    end

    // Reset mid-payload discards the frame and clears the error state
    push(8'hA5);
    push(8'h05);
    push(8'h01);
    push(8'h02);
    wait_drain();
    reset = 1'b0;
    fifo.delete();
    rx_empty = 1'b1;
    @(negedge UCLK);
    exp_err = 0;
    exp_code = 2'd0;
    check("rst2_len", {27'd0, frm_len}, 32'd0);
    check("rst2_rd", {31'd0, rd_uart}, 32'd0);
    check_err("rst2");
    reset = 1'b1;
    @(negedge UCLK);
    pl = '{8'hA5, 8'h80, 8'hFF, 8'h01};
    push_frame(8'd4, pl, csum_of(8'd4, pl));
    wait_valid("post_rst");
    check_frame("post_rst", pl);
    ack();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
